mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; the receiving end of the EXE->MEM bus and the
//  consumer of the data-SRAM read data for loads issued in EXE. It latches the
//  EXE_to_MEM bus and aligns/extends the 32-bit read word per load_op. It
//  selects the final result, drives MEM->WB and the MEM forwarding bus back to ID.
// PARAMETERS
//  EXE_TO_MEM_LEN  112  {pc[31:0],gr_we,dest[4:0],alu_res[31:0],mem_sum[31:0],mem_en,mem_we[3:0],load_op[3:0],rfrom_mem}
//  MEM_TO_WB_LEN   70   {pc[31:0],gr_we,dest[4:0],final_result[31:0]}
//  MEM_RF_LEN      38   {dest_masked[4:0],rfrom_mem,final_result[31:0]}
// PORTS
//  clk               in   1    clock, all state on posedge
//  resetn            in   1    asynchronous active-low reset
//  EXE_to_MEM_BUS    in   112  payload from EXE
//  EXE_to_MEM_valid  in   1    EXE payload valid
//  MEM_allowin       out  1    MEM may accept a new payload this cycle
//  data_sram_rdata   in   32   read word, valid the cycle after EXE asserted data_sram_en
//  WB_allowin        in   1    WB may accept
//  MEM_to_WB_valid   out  1    MEM payload valid toward WB
//  MEM_to_WB_BUS     out  70   payload to WB
//  MEM_RF_BUS        out  38   forwarding/hazard info to ID
// BEHAVIOUR
//  Reset (asynchronous, resetn=0): MEM_valid=0, bus register=0, hold state cleared.
//   Outputs: MEM_to_WB_valid=0, MEM_RF_BUS=0, MEM_allowin=1.
//  Handshake: MEM_ready_go=1. MEM_allowin = !MEM_valid | (MEM_ready_go & WB_allowin).
//   MEM_to_WB_valid = MEM_valid & MEM_ready_go.
//   Bus register loads EXE_to_MEM_BUS only when EXE_to_MEM_valid & MEM_allowin.
//   If MEM_allowin=1: MEM_valid <= EXE_to_MEM_valid. Otherwise MEM_valid and the bus register hold.
//  Latency: 1 cycle EXE->MEM. Load data is combinational from data_sram_rdata in the
//   cycle the instruction resides in MEM.
//  load_op bit encoding: [0]=byte [1]=half [2]=word [3]=unsigned. Exactly one of [2:0] is set when rfrom_mem=1.
//   Byte: rdata[8*off +: 8], off=alu_res[1:0].
//   Half: off[1]?rdata[31:16]:rdata[15:0]. off[0] is ignored; misaligned accesses raise no fault.
//   Extension: zero-extend if load_op[3]=1, else sign-extend. Word: rdata unchanged.
//  final_result = rfrom_mem ? load_data : alu_res. Stores (mem_en) pass alu_res; their gr_we is 0.
//  MEM_RF_BUS dest field = dest & {5{gr_we & MEM_valid}}. An empty stage therefore forwards dest=0,
//   which ID treats as no hazard.
//  Simultaneous leave+enter (MEM_valid & WB_allowin & EXE_to_MEM_valid): new payload
//   replaces the old one in the same edge, with no bubble.
//  WB_allowin=0 mid-load: stage holds. Data correctness then depends on CONFIGURATION below.
//  resetn asserted mid-operation: in-flight instruction is discarded. MEM_to_WB_valid=0 immediately (async).
// CONFIGURATION
//  MEM_RDATA_HOLD_EN defined:
//   - 32-bit rdata_hold register plus a hold_valid flag.
//   - On the first cycle that MEM_valid & rfrom_mem & !hold_valid holds, capture data_sram_rdata
//     and set hold_valid.
//   - Load source = hold_valid ? rdata_hold : data_sram_rdata.
//   - hold_valid clears on any bus-register load, and on reset.
//   - Result: correct data under any-length WB stall, even if the SRAM output changes.
//  MEM_RDATA_HOLD_EN undefined: no hold register. data_sram_rdata is used directly every cycle.
//   Correct only if the SRAM holds its output while no new request is issued.
// TESTING
//  1. Reset with resetn=0, then release -> MEM_to_WB_valid=0, MEM_RF_BUS=0, MEM_allowin=1.
//  2. ld.b at alu_res=0x...3, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80.
//     ld.bu at the same address -> 0x0000_0080.
//  3. ld.h at off=2, rdata=0x8001_7FFF -> 0xFFFF_8001. ld.hu at off=0 -> 0x0000_7FFF.
//  4. add: gr_we=1, dest=5, alu_res=0x1234 -> MEM_to_WB_BUS result=0x1234,
//     MEM_RF_BUS={5,0,0x1234}. Next cycle with no valid input -> dest field=0.
//  5. ld.w, WB_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after cycle 1:
//     - with MEM_RDATA_HOLD_EN -> WB receives the original word once, MEM_allowin=0 throughout;
//     - without MEM_RDATA_HOLD_EN -> MEM_allowin=0 throughout, and the result tracks the changing rdata.
//  6. Back-to-back valid instructions with WB_allowin=1 -> one per cycle, no bubble.
//     Assert resetn=0 mid-stream -> MEM_to_WB_valid drops the same cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE->MEM bus, aligns/extends load data, drives MEM->WB and forwarding.
// Optional build macro MEM_RDATA_HOLD_EN keeps the first load word across WB stalls.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic [111:0] EXE_to_MEM_BUS,
    input  logic         EXE_to_MEM_valid,
    output logic         MEM_allowin,
    input  logic [31:0]  data_sram_rdata,
    input  logic         WB_allowin,
    output logic         MEM_to_WB_valid,
    output logic [69:0]  MEM_to_WB_BUS,
    output logic [37:0]  MEM_RF_BUS
);
    localparam int EXE_TO_MEM_LEN = 112;
    localparam int MEM_TO_WB_LEN  = 70;
    localparam int MEM_RF_LEN     = 38;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] mem_sum;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [3:0]  load_op;
        logic        rfrom_mem;
    } exe_to_mem_t;

    exe_to_mem_t r_bus;
    logic        r_valid;
    logic        w_ready_go;
    logic        w_bus_load;
    logic [31:0] w_load_src;
    logic [31:0] w_load_data;
    logic [31:0] w_final;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused;

    assign w_ready_go      = 1'b1;
    assign MEM_allowin     = !r_valid | (w_ready_go & WB_allowin);
    assign MEM_to_WB_valid = r_valid & w_ready_go;
    assign w_bus_load      = EXE_to_MEM_valid & MEM_allowin;

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (MEM_allowin) begin
            r_valid <= EXE_to_MEM_valid;
            if (EXE_to_MEM_valid) begin
                r_bus <= EXE_TO_MEM_LEN'(EXE_to_MEM_BUS);
            end
        end
    end

`ifdef MEM_RDATA_HOLD_EN
    logic [31:0] r_rdata_hold;
    logic        r_hold_valid;

    // A new payload always invalidates the captured word, even if a capture would fire this edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_hold <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_bus_load) begin
            r_hold_valid <= 1'b0;
        end else if (r_valid & r_bus.rfrom_mem & !r_hold_valid) begin
            r_rdata_hold <= data_sram_rdata;
            r_hold_valid <= 1'b1;
        end
    end

    assign w_load_src = r_hold_valid ? r_rdata_hold : data_sram_rdata;
`else
    assign w_load_src = data_sram_rdata;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_load_data = w_load_src;
        w_off       = r_bus.alu_res[1:0];
        w_byte      = w_load_src[{w_off, 3'b000} +: 8];
        w_half      = w_off[1] ? w_load_src[31:16] : w_load_src[15:0];
        if (r_bus.load_op[2]) begin
            w_load_data = w_load_src;
        end else if (r_bus.load_op[1]) begin
            w_load_data = r_bus.load_op[3] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        end else if (r_bus.load_op[0]) begin
            w_load_data = r_bus.load_op[3] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end
    end

    assign w_final = r_bus.rfrom_mem ? w_load_data : r_bus.alu_res;

    assign MEM_to_WB_BUS = MEM_TO_WB_LEN'({r_bus.pc, r_bus.gr_we, r_bus.dest, w_final});
    assign MEM_RF_BUS    = MEM_RF_LEN'({r_bus.dest & {5{r_bus.gr_we & r_valid}}, r_bus.rfrom_mem, w_final});

    // Store-side fields travel on the bus but are consumed upstream.
    assign w_unused = ^{r_bus.mem_sum, r_bus.mem_en, r_bus.mem_we};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: behavioural model, per-cycle compare process, directed literal cases, random traffic.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [111:0] EXE_to_MEM_BUS = '0;
    logic         EXE_to_MEM_valid = 1'b0;
    logic         WB_allowin = 1'b1;
    logic [31:0]  data_sram_rdata = '0;
    logic         MEM_allowin;
    logic         MEM_to_WB_valid;
    logic [69:0]  MEM_to_WB_BUS;
    logic [37:0]  MEM_RF_BUS;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .EXE_to_MEM_BUS   (EXE_to_MEM_BUS),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .MEM_allowin      (MEM_allowin),
        .data_sram_rdata  (data_sram_rdata),
        .WB_allowin       (WB_allowin),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .MEM_to_WB_BUS    (MEM_to_WB_BUS),
        .MEM_RF_BUS       (MEM_RF_BUS)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [111:0] mk_bus(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                                            input logic [31:0] alu, input logic [3:0] lop, input logic rfrom,
                                            input logic mem_en, input logic [3:0] mem_we);
        return {pc, gr_we, dest, alu, alu, mem_en, mem_we, lop, rfrom};
    endfunction

    // Load extraction from the architectural rules, using shifts and masks.
    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] mask;
        int          width;
        if (op[2]) return w;
        if (op[1]) begin
            v     = off[1] ? (w >> 16) : w;
            width = 16;
        end else begin
            v     = w >> (8 * int'(off));
            width = 8;
        end
        mask = (32'h1 << width) - 32'h1;
        v    = v & mask;
        if (!op[3] && v[width-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model state: what sits in the stage and whether it is live.
    logic         m_valid = 1'b0;
    logic [111:0] m_bus = '0;
`ifdef MEM_RDATA_HOLD_EN
    logic         m_hold_v = 1'b0;
    logic [31:0]  m_hold = '0;
`endif

    always @(posedge clk or negedge resetn) begin
        logic allow;
        if (!resetn) begin
            m_valid = 1'b0;
            m_bus   = '0;
`ifdef MEM_RDATA_HOLD_EN
            m_hold_v = 1'b0;
            m_hold   = '0;
`endif
        end else begin
            allow = !m_valid || WB_allowin;
            if (EXE_to_MEM_valid && allow) begin
                m_bus = EXE_to_MEM_BUS;
`ifdef MEM_RDATA_HOLD_EN
                m_hold_v = 1'b0;
            end else if (m_valid && m_bus[0] && !m_hold_v) begin
                m_hold   = data_sram_rdata;
                m_hold_v = 1'b1;
`endif
            end
            if (allow) m_valid = EXE_to_MEM_valid;
        end
    end

    // Compare process: every outputs checked against the model on each falling edge.
    always @(negedge clk) begin
        logic [31:0] src;
        logic [31:0] fin;
        logic [4:0]  dmask;
        logic [69:0] exp_wb;
        logic [37:0] exp_rf;
        src = data_sram_rdata;
`ifdef MEM_RDATA_HOLD_EN
        if (m_hold_v) src = m_hold;
`endif
        fin    = m_bus[0] ? load_value(m_bus[4:1], m_bus[43:42], src) : m_bus[73:42];
        dmask  = (m_bus[79] && m_valid) ? m_bus[78:74] : 5'd0;
        exp_wb = {m_bus[111:80], m_bus[79], m_bus[78:74], fin};
        exp_rf = {dmask, m_bus[0], fin};
        check("allowin", 128'(MEM_allowin), 128'(!m_valid || WB_allowin));
        check("wb_valid", 128'(MEM_to_WB_valid), 128'(m_valid));
        check("wb_bus", 128'(MEM_to_WB_BUS), 128'(exp_wb));
        check("rf_bus", 128'(MEM_RF_BUS), 128'(exp_rf));
    end

    task automatic drive(input logic v, input logic [111:0] bus, input logic wb, input logic [31:0] rd);
        EXE_to_MEM_valid = v;
        EXE_to_MEM_BUS   = bus;
        WB_allowin       = wb;
        data_sram_rdata  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Issue one instruction, then observe it in MEM with the given read word.
    task automatic one(input string name, input logic [111:0] bus, input logic [31:0] rd, input logic [31:0] exp);
        drive(1'b1, bus, 1'b1, 32'h0);
        step();
        drive(1'b0, bus, 1'b1, rd);
        sample();
        check({name, "_valid"}, 128'(MEM_to_WB_valid), 128'(1'b1));
        check(name, 128'(MEM_to_WB_BUS[31:0]), 128'(exp));
    endtask

    initial begin
        logic [111:0] b;
        logic [2:0]   sz;
        logic [3:0]   lop;
        int           kind;

        #2 resetn = 1'b0;
        sample();
        check("rst_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        check("rst_rf_bus", 128'(MEM_RF_BUS), 128'(0));
        check("rst_allowin", 128'(MEM_allowin), 128'(1'b1));
        step();
        resetn = 1'b1;
        sample();
        check("post_rst_wb_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        check("post_rst_rf_bus", 128'(MEM_RF_BUS), 128'(0));
        check("post_rst_allowin", 128'(MEM_allowin), 128'(1'b1));
        step();

        one("ld_b", mk_bus(32'h100, 1'b1, 5'd3, 32'h0000_1003, 4'b0001, 1'b1, 1'b0, 4'h0), 32'h80FF_1234, 32'hFFFF_FF80);
        step();
        one("ld_bu", mk_bus(32'h104, 1'b1, 5'd3, 32'h0000_1003, 4'b1001, 1'b1, 1'b0, 4'h0), 32'h80FF_1234, 32'h0000_0080);
        step();
        one("ld_h", mk_bus(32'h108, 1'b1, 5'd4, 32'h0000_2002, 4'b0010, 1'b1, 1'b0, 4'h0), 32'h8001_7FFF, 32'hFFFF_8001);
        step();
        one("ld_hu", mk_bus(32'h10C, 1'b1, 5'd4, 32'h0000_2000, 4'b1010, 1'b1, 1'b0, 4'h0), 32'h8001_7FFF, 32'h0000_7FFF);
        step();

        one("add", mk_bus(32'h110, 1'b1, 5'd5, 32'h0000_1234, 4'b0000, 1'b0, 1'b0, 4'h0), 32'hCAFE_0000, 32'h0000_1234);
        check("add_rf", 128'(MEM_RF_BUS), 128'({5'd5, 1'b0, 32'h0000_1234}));
        step();
        sample();
        check("empty_rf", 128'(MEM_RF_BUS), 128'({5'd0, 1'b0, 32'h0000_1234}));
        step();

        // Load stalled by WB for three cycles while the SRAM output changes.
        drive(1'b1, mk_bus(32'h200, 1'b1, 5'd7, 32'h0000_3000, 4'b0100, 1'b1, 1'b0, 4'h0), 1'b1, 32'h0);
        step();
        drive(1'b1, mk_bus(32'h204, 1'b1, 5'd9, 32'h0000_5555, 4'b0000, 1'b0, 1'b0, 4'h0), 1'b0, 32'h1122_3344);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) data_sram_rdata = 32'hDEAD_BEEF;
            sample();
            check("stall_allowin", 128'(MEM_allowin), 128'(1'b0));
            check("stall_pc", 128'(MEM_to_WB_BUS[69:38]), 128'(32'h200));
`ifdef MEM_RDATA_HOLD_EN
            check("stall_word", 128'(MEM_to_WB_BUS[31:0]), 128'(32'h1122_3344));
`else
            check("stall_word", 128'(MEM_to_WB_BUS[31:0]), 128'((c == 0) ? 32'h1122_3344 : 32'hDEAD_BEEF));
`endif
            step();
        end
        drive(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        sample();
        check("release_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
        check("release_allowin", 128'(MEM_allowin), 128'(1'b1));
        step();

        // Back-to-back stream, then reset in mid-flight.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk_bus(32'h300 + 4 * i, 1'b1, 5'(i + 1), 32'hA000 + i, 4'b0000, 1'b0, 1'b0, 4'h0), 1'b1, 32'h0);
            step();
            sample();
            check("b2b_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
            check("b2b_result", 128'(MEM_to_WB_BUS[31:0]), 128'(32'hA000 + i));
        end
        resetn = 1'b0;
        #1;
        check("midrst_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        check("midrst_rf", 128'(MEM_RF_BUS), 128'(0));
        step();
        resetn = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 2);
            sz   = 3'b001 << $urandom_range(0, 2);
            lop  = {1'($urandom_range(0, 1)), sz};
            case (kind)
                0:       b = mk_bus($urandom, 1'b1, 5'($urandom), $urandom, 4'b0000, 1'b0, 1'b0, 4'h0);
                1:       b = mk_bus($urandom, 1'b1, 5'($urandom), $urandom, lop, 1'b1, 1'b0, 4'h0);
                default: b = mk_bus($urandom, 1'b0, 5'($urandom), $urandom, 4'b0000, 1'b0, 1'b1, 4'($urandom));
            endcase
            drive(1'($urandom_range(0, 9) < 7), b, 1'($urandom_range(0, 9) < 7), $urandom);
            if (n == 300) resetn = 1'b0;
            if (n == 302) resetn = 1'b1;
            step();
        end

        sample();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
